// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops WIDTH*HEIGHT pixels from a 1-cycle-latency FIFO and re-emits them as a framed valid/ready stream with checksum and starvation count
module fifo_frame_reader #(
  parameter int DWIDTH = 8,
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 56,
  parameter int CSUM_W = 16,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic [CSUM_W-1:0] checksum,
  output logic [15:0]       starve_cnt
);
  localparam int NPIX = WIDTH * HEIGHT;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d, col_q, col_d, row_q, row_d;
  logic [DWIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [1:0] cnt_q, cnt_d, kept;
  logic inflight_q, inflight_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [15:0] starve_q, starve_d;
  logic pop, room, clr, last_col, last_row;
  logic [2:0] occ;
  always_comb begin
    pop = (cnt_q != 2'd0) & out_ready;
    occ = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    room = (state_q == RUN) & (req_cnt_q < CNT_W'(NPIX)) & (occ < 3'd2);
    fifo_rdreq = room & !fifo_empty;
    clr = (state_q == IDLE) & start;
    last_col = col_q == CNT_W'(WIDTH - 1);
    last_row = row_q == CNT_W'(HEIGHT - 1);
    kept = cnt_q - {1'b0, pop};
    b0_d = (inflight_q & kept == 2'd0) ? fifo_q : pop ? b1_q : b0_q;
    b1_d = (inflight_q & kept != 2'd0) ? fifo_q : b1_q;
    cnt_d = kept + {1'b0, inflight_q};
    inflight_d = fifo_rdreq;
    req_cnt_d = clr ? '0 : req_cnt_q + CNT_W'(fifo_rdreq);
    col_d = clr ? '0 : pop ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = clr ? '0 : (pop & last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    csum_d = clr ? '0 : pop ? csum_q + CSUM_W'(b0_q) : csum_q;
    starve_d = clr ? '0 : (room & fifo_empty & starve_q != 16'hFFFF) ? starve_q + 16'd1 : starve_q;
    state_d = clr ? RUN :
              (state_q == RUN & fifo_rdreq & req_cnt_q == CNT_W'(NPIX - 1)) ? DRAIN :
              (state_q == DRAIN & pop & last_col & last_row) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      csum_q     <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      csum_q     <= csum_d;
      starve_q   <= starve_d;
    end
  end
  assign out_valid  = cnt_q != 2'd0;
  assign out_data   = b0_q;
  assign out_sof    = out_valid & col_q == '0 & row_q == '0;
  assign out_eol    = out_valid & last_col;
  assign out_eof    = out_eol & last_row;
  assign busy       = (state_q == RUN) | (state_q == DRAIN);
  assign frame_done = state_q == DONE;
  assign checksum   = csum_q;
  assign starve_cnt = starve_q;
  assert property (@(posedge clk) disable iff (!resetn) !(inflight_q && cnt_q == 2'd2 && !pop));
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed frames through a 4x2 reader fed by a 1-cycle-latency FIFO model
module tb_fifo_frame_reader;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, out_ready = 1'b1, force_empty = 1'b0;
  logic fifo_empty, fifo_rdreq, out_valid, out_sof, out_eol, out_eof, busy, frame_done;
  logic [7:0] fifo_q = 8'h00, out_data;
  logic [15:0] checksum, starve_cnt;
  logic [7:0] mem [0:63];
  int rd_ptr = 0, wr_ptr = 0, n_chk = 0, n_fail = 0, n_pop = 0, n_done = 0;
  int ncyc = 0, tcyc = 0, done_cyc = 0, rmode = 0;
  logic [7:0] cap_data [0:127];
  logic [2:0] cap_mark [0:127];
  int cap_cyc [0:127];
  logic stall_prev = 1'b0;
  logic [10:0] held = '0;
  fifo_frame_reader #(.DWIDTH(8), .WIDTH(4), .HEIGHT(2), .CSUM_W(16), .CNT_W(12)) dut (
    .clk(clk), .resetn(resetn), .start(start), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .frame_done(frame_done),
    .checksum(checksum), .starve_cnt(starve_cnt)
  );
  always #5 clk = ~clk;
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
  initial forever begin
    @(posedge clk);
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end else fifo_q <= 8'hEE;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (stall_prev && resetn) check("hold", {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, held});
    stall_prev = resetn && out_valid && !out_ready;
    held = {out_data, out_sof, out_eol, out_eof};
    if (out_valid && out_ready) begin
      cap_data[n_pop] = out_data;
      cap_mark[n_pop] = {out_sof, out_eol, out_eof};
      cap_cyc[n_pop] = ncyc;
      n_pop++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = ncyc;
    end
  end
  task automatic cycle();
    @(posedge clk);
    #1;
    tcyc++;
    out_ready = (rmode == 0) || (tcyc % 4 == 0) || (tcyc % 4 == 3);
  endtask
  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask
  task automatic run_frame(input int rm, input int sv, input bit mid, input bit tchk, input string nm);
    int base, d0, r0, k;
    logic [15:0] esum;
    logic [2:0] em;
    rmode = rm;
    base = n_pop;
    d0 = n_done;
    r0 = rd_ptr;
    esum = 16'h0;
    for (int i = 0; i < 8; i++) esum += 16'(mem[r0 + i]);
    start = 1'b1;
    force_empty = sv > 0;
    cycle();
    start = 1'b0;
    repeat (sv) cycle();
    if (sv > 0) begin
      check({nm, "_starve_nopop"}, n_pop - base, 0);
      check({nm, "_starve_valid"}, out_valid, 0);
      check({nm, "_starve_early"}, starve_cnt, sv);
    end
    force_empty = 1'b0;
    k = 0;
    while (n_done == d0 && k < 200) begin
      cycle();
      start = mid && k == 3;
      k++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, n_done - d0, 1);
    check({nm, "_npop"}, n_pop - base, 8);
    for (int i = 0; i < 8; i++) begin
      em = {i == 0, i == 3 || i == 7, i == 7};
      check($sformatf("%s_data%0d", nm, i), cap_data[base + i], mem[r0 + i]);
      check($sformatf("%s_mark%0d", nm, i), cap_mark[base + i], em);
    end
    check({nm, "_csum"}, checksum, esum);
    check({nm, "_starve"}, starve_cnt, sv);
    if (tchk) begin
      check({nm, "_burst"}, cap_cyc[base + 7] - cap_cyc[base], 7);
      check({nm, "_done_lat"}, done_cyc - cap_cyc[base + 7], 1);
    end
    repeat (5) cycle();
    check({nm, "_done_once"}, n_done - d0, 1);
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_idle_valid"}, out_valid, 0);
    check({nm, "_csum_hold"}, checksum, esum);
  endtask
  initial begin
    int base, k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_csum", checksum, 0);
    check("rst_starve", starve_cnt, 0);
    check("rst_rdreq", fifo_rdreq, 0);
    resetn = 1'b1;
    cycle();
    for (int i = 1; i <= 8; i++) push(8'(i));
    run_frame(0, 0, 1'b0, 1'b1, "A");
    check("A_csum_hand", checksum, 16'h0024);
    for (int i = 1; i <= 8; i++) push(8'(i));
    run_frame(1, 0, 1'b0, 1'b0, "B");
    check("B_csum_hand", checksum, 16'h0024);
    for (int i = 1; i <= 8; i++) push(8'(i));
    run_frame(0, 5, 1'b0, 1'b0, "C");
    for (int i = 1; i <= 8; i++) push(8'hFF);
    run_frame(0, 0, 1'b0, 1'b0, "D");
    check("D_csum_hand", checksum, 16'h07F8);
    for (int i = 1; i <= 8; i++) push(8'(i));
    rmode = 0;
    base = n_pop;
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 0;
    while (n_pop - base < 3 && k < 50) begin
      cycle();
      k++;
    end
    check("rst_mid_pops", n_pop - base, 3);
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_csum", checksum, 0);
    check("rst_mid_starve", starve_cnt, 0);
    check("rst_mid_rdreq", fifo_rdreq, 0);
    check("rst_mid_marks", {out_sof, out_eol, out_eof}, 0);
    check("rst_mid_data", out_data, 0);
    cycle();
    resetn = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    run_frame(0, 0, 1'b0, 1'b0, "E");
    for (int i = 1; i <= 8; i++) push(8'(i));
    run_frame(0, 0, 1'b1, 1'b0, "F");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side counterpart to the feature-map stream generator that writes pixels into a FIFO.
- Pops exactly WIDTH*HEIGHT pixels from a normal-mode FIFO (1-cycle read latency) once armed by start.
- Re-emits the pixels as a valid/ready stream with sof/eol/eof framing, and produces a frame checksum and a starvation count.
- Sits between the inter-layer FIFO and the next VGG16 layer input, or a bench result sink.

Parameters:
DWIDTH, 8, pixel width in bits
WIDTH, 56, pixels per row
HEIGHT, 56, rows per frame
CSUM_W, 16, checksum width in bits; sum of pixels modulo 2^CSUM_W
CNT_W, 12, width of the pixel counters; must satisfy 2^CNT_W > WIDTH*HEIGHT

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that arms one frame; ignored unless IDLE
fifo_empty  in  1  FIFO empty flag
fifo_rdreq  out  1  FIFO read request; combinational from registered state and out_ready
fifo_q  in  DWIDTH  FIFO data, valid in the cycle after fifo_rdreq
out_data  out  DWIDTH  pixel at the head of the skid buffer
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the pixel
out_sof  out  1  qualifies out_data as the first pixel of the frame
out_eol  out  1  qualifies out_data as the last pixel of a row
out_eof  out  1  qualifies out_data as the last pixel of the frame
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse at end of frame
checksum  out  CSUM_W  sum of accepted pixels; stable from frame_done until the next start
starve_cnt  out  16  cycles in RUN blocked only by fifo_empty; saturates at 0xFFFF

Behaviour:
- Reset is asynchronous and active-low (resetn); clock is clk.
- Reset values: every output register is 0, state is IDLE, buffer is empty, inflight is 0, counters are 0.
- Reset mid-frame discards the in-flight read and buffered data. FIFO contents are not flushed.
- State IDLE:
  - On start: clear checksum, starve_cnt, req_cnt, col and row, then go to RUN.
- State RUN: issues reads.
  - Define occ = buffer entries (0..2) + inflight (0/1) - pop, where pop = out_valid & out_ready.
  - fifo_rdreq = (state==RUN) & !fifo_empty & (req_cnt < WIDTH*HEIGHT) & (occ < 2).
  - When all WIDTH*HEIGHT reads have been issued, go to DRAIN.
- State DRAIN: no reads are issued. Wait for the eof pixel to be accepted, then go to DONE.
- State DONE: drive frame_done = 1 for exactly one cycle, then go to IDLE.
- Read pipeline:
  - fifo_rdreq in cycle t sets inflight for cycle t+1.
  - fifo_q is written into the 2-entry skid buffer at the end of cycle t+1.
  - out_valid is high no earlier than cycle t+2.
- Throughput: with out_ready held high and the FIFO non-empty, one pixel per cycle is sustained.
- The buffer never overflows: any write while 2 entries are held and pop=0 is a design error, flagged by an assertion.
- Backpressure: out_data and the markers hold stable while out_valid & !out_ready.
- Framing (col/row advance on each pop):
  - out_sof = (col==0 & row==0).
  - out_eol = (col==WIDTH-1).
  - out_eof = out_eol & (row==HEIGHT-1).
  - col wraps to 0 after WIDTH-1 and row increments.
- Checksum: checksum += out_data on each pop; wraps modulo 2^CSUM_W.
- starve_cnt increments on cycles where state==RUN & req_cnt<WIDTH*HEIGHT & occ<2 & fifo_empty.
- Simultaneous events:
  - A buffer write and a pop in the same cycle keep the occupancy unchanged.
  - start during RUN, DRAIN or DONE is ignored.
  - start in the same cycle as the DONE-to-IDLE transition is ignored; it is accepted from the IDLE cycle onward.
- High-Z or X on fifo_q when no read is outstanding must not propagate: the buffer loads only from reads that are in flight.

Test Plan:
- WIDTH=4, HEIGHT=2; FIFO preloaded with 0x01..0x08; start; out_ready=1 -> 8 pops in 8 consecutive cycles, data 01..08. sof on 01; eol on 04 and 08; eof on 08. frame_done one cycle after the 08 pop. checksum=0x0024, starve_cnt=0.
- Same frame, out_ready toggling 1,0,0,1 repeating -> identical data order and markers, no lost or duplicated pixels. Data stable while stalled; fifo_rdreq never pushes the buffer past 2 entries.
- FIFO empty for 5 cycles after start, then fed -> starve_cnt=5, no output until the first data arrives, frame completes normally.
- Pixels all 0xFF, WIDTH=HEIGHT=16, CSUM_W=16 -> checksum = 256*255 mod 65536 = 0xFF00.
- resetn asserted after the 3rd pop -> all outputs 0 and IDLE immediately. A new start re-frames from sof, with checksum counting only the new pops.
- start pulsed during RUN -> ignored, req_cnt is not reset, exactly 8 pops and one frame_done.
